// File: rtl/m_mem_pkg.sv
// Shared definitions for the M-stage memory initiator: size codes, FSM states,
// default data-memory depth and the alignment/size fault helper.
package m_mem_pkg;

    localparam int DM_WORDS_DEF = 3072;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

    // Illegal size code or an address not naturally aligned to the access size.
    function automatic logic size_fault(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/m_mem_lane.sv
// Byte-lane datapath: merges sub-word store data into a read word and
// extracts/extends the addressed lane(s) of a read word for loads.
module m_mem_lane
    import m_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rbuf_i,
    output logic [31:0] merged_o,
    output logic [31:0] loaded_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;

            // Byte stores always source wdata[7:0]; halves source the matching byte of wdata[15:0].
            always_comb begin
                hit = 1'b1;
                src = wdata_i[8*gi +: 8];
                case (size_i)
                    SZ_B: begin
                        hit = (lane_i == LANE);
                        src = wdata_i[7:0];
                    end
                    SZ_H: begin
                        hit = (lane_i[1] == LANE[1]);
                        src = wdata_i[8*(gi%2) +: 8];
                    end
                    default: begin
                        hit = 1'b1;
                        src = wdata_i[8*gi +: 8];
                    end
                endcase
            end

            assign merged_o[8*gi +: 8] = hit ? src : rbuf_i[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  byte_d;
    logic [15:0] half_d;

    always_comb begin
        byte_d   = rbuf_i[{lane_i, 3'b000} +: 8];
        half_d   = lane_i[1] ? rbuf_i[31:16] : rbuf_i[15:0];
        loaded_o = rbuf_i;
        case (size_i)
            SZ_B:    loaded_o = {{24{sign_i & byte_d[7]}}, byte_d};
            SZ_H:    loaded_o = {{16{sign_i & half_d[15]}}, half_d};
            default: loaded_o = rbuf_i;
        endcase
    end

endmodule

// File: rtl/m_mem_initiator.sv
// M-stage memory initiator: turns byte/half/word CPU accesses into word-only
// data-memory cycles, using read-modify-write for sub-word stores.
module m_mem_initiator
    import m_mem_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              dm_we,
    output logic [31:0]       dm_addr,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd,
    output logic [31:0]       dm_pc
);

    state_t            state_q;
    logic              we_q;
    logic              sign_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       pc_q;
    logic [31:0]       rbuf_q;

    logic              req_err_d;
    logic [31:0]       merged_d;
    logic [31:0]       loaded_d;

    always_comb begin
        req_err_d = size_fault(req_size, req_addr[1:0])
                  || (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DM_WORDS));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rbuf_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        sign_q  <= req_sign;
                        err_q   <= req_err_d;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
                        // Faulting requests never touch memory; whole-word stores skip the read.
                        if (req_err_d)
                            state_q <= ST_RESP;
                        else if (req_we && req_size == SZ_W)
                            state_q <= ST_WR;
                        else
                            state_q <= ST_RD;
                    end
                end
                ST_RD: begin
                    rbuf_q  <= dm_rd;
                    state_q <= we_q ? ST_WR : ST_RESP;
                end
                ST_WR:   state_q <= ST_RESP;
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    m_mem_lane u_lane (
        .size_i   (size_q),
        .sign_i   (sign_q),
        .lane_i   (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rbuf_i   (rbuf_q),
        .merged_o (merged_d),
        .loaded_o (loaded_d)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? loaded_d : 32'h0;

    // Gating with reset kills a write already in flight when reset lands mid-WR.
    assign dm_we   = (state_q == ST_WR) && reset;
    assign dm_addr = 32'({addr_q[ADDR_W-1:2], 2'b00});
    assign dm_wd   = (state_q == ST_WR) ? merged_d : 32'h0;
    assign dm_pc   = pc_q;

endmodule
